cmsdk_mcu_sleep_pmu: RTL
========================

// Module: cmsdk_mcu_sleep_pmu
// PURPOSE
//  Sleep/power sequencer that sits beside the MCU clock/reset controller. It watches the
//  processor SLEEPING/SLEEPDEEP status, gates HCLK via HCLKEN, and runs the SLEEPHOLD
//  handshake for deep sleep. It drives OSC_STOP into the clock controller's SLEEPDEEP input
//  and sequences a timed oscillator-settle period on wake-up.
//  clk is an always-running clock (not the gated HCLK) and is unaffected by OSC_STOP.
// PARAMETERS
//  ENTER_DLY     2   cycles SLEEPING must hold (no wake/debug) before gating; >=1
//  WAKE_DLY      4   cycles in WAKE before HCLKEN returns after deep sleep; >=1
//  HOLD_TIMEOUT  15  max cycles in HOLD waiting for SLEEPHOLDACKn; >=1
//  CNT_W         4   counter width; 2**CNT_W-1 >= max(ENTER_DLY,WAKE_DLY,HOLD_TIMEOUT)
// PORTS
//  clk            in   1  always-running sequencer clock
//  NRST           in   1  reset, asynchronous, active-low
//  SLEEPING       in   1  core sleep status (sync to clk)
//  SLEEPDEEP      in   1  core deep-sleep status (sync to clk)
//  WAKEUP         in   1  wake request, level, pre-synchronised to clk
//  DBGPWRUPREQ    in   1  debugger power-up request; forces/keeps RUN
//  SLEEPHOLDACKn  in   1  core hold acknowledge, active-low
//  HCLKEN         out  1  HCLK gate enable (1 = clock runs)
//  SLEEPHOLDREQn  out  1  hold request to core, active-low
//  OSC_STOP       out  1  stop main oscillator (to clkctrl SLEEPDEEP)
//  HOLDFAIL       out  1  1-cycle pulse: hold handshake timed out
//  PMU_STATE      out  3  current FSM state encoding (debug)
// BEHAVIOUR
//  - All outputs registered. On NRST low: state=RUN, cnt=0, HCLKEN=1, SLEEPHOLDREQn=1,
//    OSC_STOP=0, HOLDFAIL=0. Reset mid-sequence returns to RUN immediately.
//  - Encoding: RUN=0, ARM=1, SLEEP=2, HOLD=3, DEEP=4, WAKE=5.
//  - Abort term: abort = WAKEUP | DBGPWRUPREQ. Abort has priority over any forward transition
//    taken in the same cycle.
//  - RUN: if SLEEPING & ~abort, go to ARM with cnt=0.
//  - ARM: if ~SLEEPING | abort, go to RUN. Otherwise cnt++.
//    When cnt==ENTER_DLY-1: go to HOLD if SLEEPDEEP, else to SLEEP; cnt=0.
//  - SLEEP: HCLKEN=0 from the cycle after entry, so gating latency is ENTER_DLY+1 clk
//    cycles from SLEEPING rising. If abort | ~SLEEPING, go to RUN; HCLKEN=1 on the next edge.
//  - HOLD: SLEEPHOLDREQn=0, HCLKEN=1, cnt++.
//    If abort: go to RUN and release the request.
//    Else if SLEEPHOLDACKn==0: go to DEEP.
//    Else if cnt==HOLD_TIMEOUT-1: go to RUN with HOLDFAIL=1 for one cycle.
//  - DEEP: HCLKEN=0, SLEEPHOLDREQn=0, OSC_STOP=1. On abort, go to WAKE with cnt=0.
//    SLEEPING/SLEEPDEEP are ignored while in DEEP.
//  - WAKE: OSC_STOP=0, HCLKEN=0, SLEEPHOLDREQn=0, cnt++.
//    When cnt==WAKE_DLY-1, go to RUN: HCLKEN=1 and SLEEPHOLDREQn=1 on the same edge.
//    Abort is ignored in WAKE (the settle time is always honoured).
//  - Register the next-state output values so outputs change on the same edge as the state.
//  - cnt saturates and never wraps; it is cleared on every state change.
// TESTING
//  1. Reset: NRST low mid-DEEP -> next cycle HCLKEN=1, OSC_STOP=0, SLEEPHOLDREQn=1, PMU_STATE=0.
//  2. Shallow sleep: SLEEPING=1, SLEEPDEEP=0 -> HCLKEN=0 3 cycles later; WAKEUP=1 -> HCLKEN=1
//     on the next edge.
//  3. Deep sleep: SLEEPDEEP=1, ack after 2 cycles -> OSC_STOP=1; WAKEUP -> OSC_STOP=0 at once,
//     HCLKEN=1 exactly 4 cycles later.
//  4. Hold timeout: SLEEPHOLDACKn held 1 -> after 15 HOLD cycles, HOLDFAIL pulses for 1 cycle
//     and state=RUN.
//  5. Abort races: SLEEPING drops in the last ARM cycle -> RUN, no gating. DBGPWRUPREQ=1 with
//     SLEEPING=1 -> HCLKEN stays 1 throughout.
//  6. WAKEUP pulse in the WAKE state -> ignored; RUN is reached exactly at WAKE_DLY.

Source files
------------

// File: rtl/cmsdk_mcu_sleep_pmu.sv
// Sleep/power sequencer beside the MCU clock/reset controller: gates HCLK, runs the
// SLEEPHOLD handshake for deep sleep, stops the oscillator and times its settle on wake.
module cmsdk_mcu_sleep_pmu #(
    parameter int unsigned ENTER_DLY    = 2,
    parameter int unsigned WAKE_DLY     = 4,
    parameter int unsigned HOLD_TIMEOUT = 15,
    parameter int unsigned CNT_W        = 4
) (
    input  logic       clk,
    input  logic       NRST,
    input  logic       SLEEPING,
    input  logic       SLEEPDEEP,
    input  logic       WAKEUP,
    input  logic       DBGPWRUPREQ,
    input  logic       SLEEPHOLDACKn,
    output logic       HCLKEN,
    output logic       SLEEPHOLDREQn,
    output logic       OSC_STOP,
    output logic       HOLDFAIL,
    output logic [2:0] PMU_STATE
);

    typedef enum logic [2:0] {
        ST_RUN   = 3'd0,
        ST_ARM   = 3'd1,
        ST_SLEEP = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DEEP  = 3'd4,
        ST_WAKE  = 3'd5
    } pmu_state_t;

    localparam logic [CNT_W-1:0] ENTER_LAST_C = CNT_W'(ENTER_DLY - 32'd1);
    localparam logic [CNT_W-1:0] WAKE_LAST_C  = CNT_W'(WAKE_DLY - 32'd1);
    localparam logic [CNT_W-1:0] HOLD_LAST_C  = CNT_W'(HOLD_TIMEOUT - 32'd1);
    localparam logic [CNT_W-1:0] CNT_MAX_C    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE_C    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO_C   = {CNT_W{1'b0}};

    pmu_state_t       state_r;
    pmu_state_t       state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             cnt_step_s;
    logic             abort_s;
    logic             hclken_r;
    logic             hclken_nxt_s;
    logic             holdreq_n_r;
    logic             holdreq_n_nxt_s;
    logic             osc_stop_r;
    logic             osc_stop_nxt_s;
    logic             holdfail_r;
    logic             holdfail_nxt_s;

    assign abort_s = WAKEUP | DBGPWRUPREQ;

    // Next-state selection; abort is tested first wherever it can pre-empt a forward move.
    always_comb begin
        state_nxt_s    = state_r;
        cnt_step_s     = 1'b0;
        holdfail_nxt_s = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (SLEEPING && !abort_s) begin
                    state_nxt_s = ST_ARM;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_ARM: begin
                if (!SLEEPING || abort_s) begin
                    state_nxt_s = ST_RUN;
                end else if (cnt_r == ENTER_LAST_C) begin
                    state_nxt_s = SLEEPDEEP ? ST_HOLD : ST_SLEEP;
                end else begin
                    state_nxt_s = ST_ARM;
                    cnt_step_s  = 1'b1;
                end
            end
            ST_SLEEP: begin
                if (abort_s || !SLEEPING) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_SLEEP;
                end
            end
            ST_HOLD: begin
                if (abort_s) begin
                    state_nxt_s = ST_RUN;
                end else if (!SLEEPHOLDACKn) begin
                    state_nxt_s = ST_DEEP;
                end else if (cnt_r == HOLD_LAST_C) begin
                    state_nxt_s    = ST_RUN;
                    holdfail_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = ST_HOLD;
                    cnt_step_s  = 1'b1;
                end
            end
            ST_DEEP: begin
                if (abort_s) begin
                    state_nxt_s = ST_WAKE;
                end else begin
                    state_nxt_s = ST_DEEP;
                end
            end
            ST_WAKE: begin
                // The oscillator settle time is never shortened, so abort is not consulted here.
                if (cnt_r == WAKE_LAST_C) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_WAKE;
                    cnt_step_s  = 1'b1;
                end
            end
            default: begin
                state_nxt_s = ST_RUN;
            end
        endcase
    end

    // Counter: cleared on any state change, otherwise a saturating step when requested.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (state_nxt_s != state_r) begin
            cnt_nxt_s = CNT_ZERO_C;
        end else if (cnt_step_s && (cnt_r != CNT_MAX_C)) begin
            cnt_nxt_s = cnt_r + CNT_ONE_C;
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Output values decoded from the next state so they register on the same edge as it.
    always_comb begin
        hclken_nxt_s    = 1'b1;
        holdreq_n_nxt_s = 1'b1;
        osc_stop_nxt_s  = 1'b0;
        case (state_nxt_s)
            ST_RUN, ST_ARM: begin
                hclken_nxt_s    = 1'b1;
                holdreq_n_nxt_s = 1'b1;
                osc_stop_nxt_s  = 1'b0;
            end
            ST_SLEEP: begin
                hclken_nxt_s    = 1'b0;
                holdreq_n_nxt_s = 1'b1;
                osc_stop_nxt_s  = 1'b0;
            end
            ST_HOLD: begin
                hclken_nxt_s    = 1'b1;
                holdreq_n_nxt_s = 1'b0;
                osc_stop_nxt_s  = 1'b0;
            end
            ST_DEEP: begin
                hclken_nxt_s    = 1'b0;
                holdreq_n_nxt_s = 1'b0;
                osc_stop_nxt_s  = 1'b1;
            end
            ST_WAKE: begin
                hclken_nxt_s    = 1'b0;
                holdreq_n_nxt_s = 1'b0;
                osc_stop_nxt_s  = 1'b0;
            end
            default: begin
                hclken_nxt_s    = 1'b1;
                holdreq_n_nxt_s = 1'b1;
                osc_stop_nxt_s  = 1'b0;
            end
        endcase
    end

    // State, counter and output registers.
    always_ff @(posedge clk or negedge NRST) begin
        if (!NRST) begin
            state_r     <= ST_RUN;
            cnt_r       <= CNT_ZERO_C;
            hclken_r    <= 1'b1;
            holdreq_n_r <= 1'b1;
            osc_stop_r  <= 1'b0;
            holdfail_r  <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            hclken_r    <= hclken_nxt_s;
            holdreq_n_r <= holdreq_n_nxt_s;
            osc_stop_r  <= osc_stop_nxt_s;
            holdfail_r  <= holdfail_nxt_s;
        end
    end

    assign HCLKEN        = hclken_r;
    assign SLEEPHOLDREQn = holdreq_n_r;
    assign OSC_STOP      = osc_stop_r;
    assign HOLDFAIL      = holdfail_r;
    assign PMU_STATE     = state_r;

endmodule
